// File: rtl/rx_pkg.sv
// ----------------------------------------------------------------------------
// rx_pkg
//   Definitions shared by the UART receive frame sequencer and its
//   redundant register primitive:
//     - one-hot state encodings and the state enum built from them
//     - legal data-bit range (DATA_MIN..DATA_MAX) and a clamp helper
//     - vote3: single-bit majority voter used by tmr_reg
// ----------------------------------------------------------------------------
package rx_pkg;

    localparam logic [4:0] INTERVAL  = 5'b00001;
    localparam logic [4:0] STARTBIT  = 5'b00010;
    localparam logic [4:0] DATABITS  = 5'b00100;
    localparam logic [4:0] PARITYBIT = 5'b01000;
    localparam logic [4:0] STOPBIT   = 5'b10000;

    typedef enum logic [4:0] {
        ST_INTERVAL  = INTERVAL,
        ST_STARTBIT  = STARTBIT,
        ST_DATABITS  = DATABITS,
        ST_PARITYBIT = PARITYBIT,
        ST_STOPBIT   = STOPBIT
    } state_e;

    localparam int unsigned DATA_MIN = 5;
    localparam int unsigned DATA_MAX = 9;

    // Majority of three copies of one bit.
    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Out-of-range data-bit requests are pulled onto the nearest legal value.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] n);
        if (n < 4'(DATA_MIN)) return 4'(DATA_MIN);
        if (n > 4'(DATA_MAX)) return 4'(DATA_MAX);
        return n;
    endfunction

endpackage

// File: rtl/tmr_reg.sv
// ----------------------------------------------------------------------------
// tmr_reg
//   W-bit register with optional triple-modular redundancy. With TMR_EN=1
//   three copies capture the same next value and the output is their
//   bitwise majority, so a single upset copy is masked and then rewritten
//   by the next capture. With TMR_EN=0 it is a plain register.
// Ports
//   clk  in  1   system clock
//   rst  in  1   asynchronous reset, active-low (loads RST_VAL)
//   d_i  in  W   next value
//   q_o  out W   voted (or single) registered value
// ----------------------------------------------------------------------------
module tmr_reg
    import rx_pkg::*;
#(
    parameter int unsigned    W       = 1,
    parameter bit             TMR_EN  = 1'b1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (TMR_EN) begin : g_tmr
            logic [W-1:0] copy0_q;
            logic [W-1:0] copy1_q;
            logic [W-1:0] copy2_q;

            // NOTE: clocked state uses non-blocking assignments so every
            // copy samples the same pre-edge d_i regardless of block order.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    copy0_q <= RST_VAL;
                    copy1_q <= RST_VAL;
                    copy2_q <= RST_VAL;
                end else begin
                    copy0_q <= d_i;
                    copy1_q <= d_i;
                    copy2_q <= d_i;
                end
            end

            always_comb begin
                for (int i = 0; i < int'(W); i++) begin
                    q_o[i] = vote3(copy0_q[i], copy1_q[i], copy2_q[i]);
                end
            end
        end else begin : g_single
            logic [W-1:0] reg_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) reg_q <= RST_VAL;
                else      reg_q <= d_i;
            end

            assign q_o = reg_q;
        end
    endgenerate

endmodule

// File: rtl/fsm_rx_frame.sv
// ----------------------------------------------------------------------------
// fsm_rx_frame
//   UART receive frame sequencer: start bit, 5..9 data bits, optional
//   parity bit, 1 or 2 stop bits. Frame format is latched when the start
//   edge is accepted and held for the whole frame. Flags false start,
//   framing error and watchdog timeout; pulses ByteDone_o on the final
//   stop bit. State, bit counter, stop counter and watchdog live in
//   tmr_reg instances (optionally triplicated).
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   p_Enable_i          core enable; low forces INTERVAL
//   Rx_Synch_i          start edge detected (pulse)
//   Bit_Synch_i         end of current bit (pulse)
//   RxBit_i             sampled value of the bit ending now
//   AcqSig_i            16x-baud tick feeding the watchdog
//   p_DataBits_i        data bits per frame (clamped to 5..9)
//   p_ParityEnable_i    parity bit present
//   p_StopBits_i        0: one stop bit, 1: two
//   State_o             one-hot state
//   BitCounter_o        index of current data bit
//   ByteDone_o, FrameErr_o, FalseStart_o, Timeout_o   1-cycle pulses
// ----------------------------------------------------------------------------
module fsm_rx_frame
    import rx_pkg::*;
#(
    parameter bit          TMR_EN    = 1'b1,
    parameter int unsigned WDT_TICKS = 48,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_Enable_i,
    input  logic             Rx_Synch_i,
    input  logic             Bit_Synch_i,
    input  logic             RxBit_i,
    input  logic             AcqSig_i,
    input  logic [3:0]       p_DataBits_i,
    input  logic             p_ParityEnable_i,
    input  logic             p_StopBits_i,
    output logic [4:0]       State_o,
    output logic [CNT_W-1:0] BitCounter_o,
    output logic             ByteDone_o,
    output logic             FrameErr_o,
    output logic             FalseStart_o,
    output logic             Timeout_o
);

    localparam int unsigned      WDT_W    = $clog2(WDT_TICKS + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TICKS - 1);

    logic [4:0]       state_q,   state_d;
    logic [CNT_W-1:0] bitcnt_q,  bitcnt_d;
    logic [0:0]       stopcnt_q, stopcnt_d;
    logic [WDT_W-1:0] wdt_q,     wdt_d;

    // Frame format captured at start-edge acceptance.
    logic [3:0] ndata_q;
    logic       par_q;
    logic       stop2_q;

    logic latch_cfg;
    logic done_d, ferr_d, fstart_d, tout_d;
    logic done_q, ferr_q, fstart_q, tout_q;

    logic [CNT_W-1:0] last_idx;
    assign last_idx = CNT_W'(ndata_q - 4'd1);

    tmr_reg #(.W(5), .TMR_EN(TMR_EN), .RST_VAL(INTERVAL)) u_state (
        .clk(clk), .rst(rst), .d_i(state_d), .q_o(state_q)
    );
    tmr_reg #(.W(CNT_W), .TMR_EN(TMR_EN), .RST_VAL('0)) u_bitcnt (
        .clk(clk), .rst(rst), .d_i(bitcnt_d), .q_o(bitcnt_q)
    );
    tmr_reg #(.W(1), .TMR_EN(TMR_EN), .RST_VAL(1'b0)) u_stopcnt (
        .clk(clk), .rst(rst), .d_i(stopcnt_d), .q_o(stopcnt_q)
    );
    tmr_reg #(.W(WDT_W), .TMR_EN(TMR_EN), .RST_VAL('0)) u_wdt (
        .clk(clk), .rst(rst), .d_i(wdt_d), .q_o(wdt_q)
    );

    always_comb begin
        // NOTE: every output of this block gets a default up front so no
        // path through the case below can leave one unassigned (no latch).
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        wdt_d     = wdt_q;
        latch_cfg = 1'b0;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        fstart_d  = 1'b0;
        tout_d    = 1'b0;

        if (state_q == ST_INTERVAL || Bit_Synch_i) wdt_d = '0;
        else if (AcqSig_i)                          wdt_d = wdt_q + 1'b1;

        if (!p_Enable_i) begin
            state_d = ST_INTERVAL;
        end else if (state_q != ST_INTERVAL && !Bit_Synch_i && AcqSig_i
                     && wdt_q == WDT_LAST) begin
            // This tick would bring the watchdog to its limit; a bit edge
            // on the same cycle would have cleared it instead.
            state_d = ST_INTERVAL;
            tout_d  = 1'b1;
        end else begin
            case (state_q)
                ST_INTERVAL: begin
                    if (Rx_Synch_i) begin
                        state_d   = ST_STARTBIT;
                        latch_cfg = 1'b1;
                    end
                end
                ST_STARTBIT: begin
                    if (Bit_Synch_i) begin
                        if (RxBit_i) begin
                            state_d  = ST_INTERVAL;
                            fstart_d = 1'b1;
                        end else begin
                            state_d = ST_DATABITS;
                        end
                    end
                end
                ST_DATABITS: begin
                    if (Bit_Synch_i) begin
                        if (bitcnt_q == last_idx) state_d = par_q ? ST_PARITYBIT : ST_STOPBIT;
                        else                      bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                ST_PARITYBIT: begin
                    if (Bit_Synch_i) state_d = ST_STOPBIT;
                end
                ST_STOPBIT: begin
                    if (Bit_Synch_i) begin
                        ferr_d = ~RxBit_i;
                        if (stop2_q && stopcnt_q == 1'b0) begin
                            stopcnt_d = 1'b1;
                        end else begin
                            state_d = ST_INTERVAL;
                            done_d  = 1'b1;
                        end
                    end
                end
                // Corrupted (non-one-hot) voted state recovers to idle.
                default: state_d = ST_INTERVAL;
            endcase
        end

        if (state_d != ST_DATABITS) bitcnt_d  = '0;
        if (state_d != ST_STOPBIT)  stopcnt_d = '0;
        if (state_d == ST_INTERVAL) wdt_d     = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ndata_q  <= 4'(DATA_MIN);
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            fstart_q <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            if (latch_cfg) begin
                ndata_q <= clamp_data_bits(p_DataBits_i);
                par_q   <= p_ParityEnable_i;
                stop2_q <= p_StopBits_i;
            end
            done_q   <= done_d;
            ferr_q   <= ferr_d;
            fstart_q <= fstart_d;
            tout_q   <= tout_d;
        end
    end

    assign State_o      = state_q;
    assign BitCounter_o = bitcnt_q;
    assign ByteDone_o   = done_q;
    assign FrameErr_o   = ferr_q;
    assign FalseStart_o = fstart_q;
    assign Timeout_o    = tout_q;

endmodule
